// File: rtl/hbridge_driver.sv
// rtl/hbridge_driver.sv - H-bridge gate driver with dead-time insertion between conduction modes
module hbridge_driver #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic waveOut,
    input  logic sign,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic deadActive
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_FREE,
        ST_POS,
        ST_NEG,
        ST_DEAD
    } state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    state_t     req;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [4:0] pat_next;

    always_comb begin
        req = ST_OFF;
        if (!en)          req = ST_OFF;
        else if (!waveOut) req = ST_FREE;
        else if (sign)    req = ST_NEG;
        else              req = ST_POS;
    end

    // Disabling is always safe, so it bypasses dead time; every other change is gated by DEAD.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!en) begin
            state_next = ST_OFF;
            cnt_next   = 8'd0;
        end else if (state == ST_DEAD) begin
            if (cnt != 8'd0) cnt_next = cnt - 8'd1;
            else             state_next = req;
        end else if (req != state) begin
            state_next = ST_DEAD;
            cnt_next   = DEAD_LOAD;
        end
    end

    // Gate pattern {A,B,C,D,deadActive} decoded from the next state so the pins are pure flops.
    always_comb begin
        pat_next = 5'b00000;
        case (state_next)
            ST_FREE: pat_next = 5'b01010;
            ST_POS:  pat_next = 5'b10010;
            ST_NEG:  pat_next = 5'b01100;
            ST_DEAD: pat_next = 5'b00001;
            default: pat_next = 5'b00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
            cnt   <= 8'd0;
            {A, B, C, D, deadActive} <= 5'b00000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            {A, B, C, D, deadActive} <= pat_next;
        end
    end

endmodule

// File: tb/tb_hbridge_driver.sv
// tb/tb_hbridge_driver.sv - scoreboard bench for hbridge_driver with directed and random stimulus
module tb_hbridge_driver;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset, en, waveOut, sign;
    logic A, B, C, D, deadActive;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];

    // Reference model: 0 OFF, 1 FREE, 2 POS, 3 NEG, 4 DEAD; dead_left counts remaining DEAD cycles.
    int m_state = 0;
    int dead_left = 0;

    logic [3:0] prev_nz = 4'b0000;
    int         zrun = 0;

    always #5 clk = ~clk;

    hbridge_driver #(.DEAD_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .waveOut(waveOut),
        .sign(sign),
        .A(A),
        .B(B),
        .C(C),
        .D(D),
        .deadActive(deadActive)
    );

    function automatic logic [4:0] pat(input int m);
        case (m)
            1:       return 5'b01010;
            2:       return 5'b10010;
            3:       return 5'b01100;
            4:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic w, input logic s);
        int rq;
        rq = !e ? 0 : (!w ? 1 : (s ? 3 : 2));
        if (r) begin
            m_state = 0;
            dead_left = 0;
        end else if (!e) begin
            m_state = 0;
        end else if (m_state == 4) begin
            if (dead_left <= 1) m_state = rq;
            else dead_left--;
        end else if (rq != m_state) begin
            m_state = 4;
            dead_left = DC;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic w, input logic s);
        logic [4:0] got;
        logic [4:0] expv;
        logic [3:0] abcd;
        logic       legal;
        reset = r; en = e; waveOut = w; sign = s;
        model_step(r, e, w, s);
        exp_q.push_back(pat(m_state));
        @(posedge clk);
        #1;
        got  = {A, B, C, D, deadActive};
        expv = exp_q.pop_front();
        chk("model", got, expv);
        abcd  = got[4:1];
        legal = !(A & B) && !(C & D) && !(A & C) && !(B & C & (A | D))
                && (got == 5'b00000 || got == 5'b01010 || got == 5'b10010
                    || got == 5'b01100 || got == 5'b00001);
        chk("legal_pattern", {4'b0, legal}, 5'b00001);
        if (abcd != 4'b0000) begin
            if (prev_nz != 4'b0000 && abcd != prev_nz)
                chk("dead_gap", {4'b0, zrun >= DC}, 5'b00001);
            prev_nz = abcd;
            zrun = 0;
        end else begin
            zrun++;
        end
    endtask

    function automatic logic [4:0] cur();
        return {A, B, C, D, deadActive};
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; waveOut = 1'b0; sign = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            chk("reset", cur(), 5'b00000);
        end
        for (int i = 0; i < DC; i++) begin
            step(0, 1, 0, 0);
            chk("release_dead", cur(), 5'b00001);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("free", cur(), 5'b01010);
        end

        for (int i = 0; i < DC; i++) begin
            step(0, 1, 1, 0);
            chk("free_to_pos_dead", cur(), 5'b00001);
        end
        step(0, 1, 1, 0);
        chk("pos", cur(), 5'b10010);

        for (int i = 0; i < DC; i++) begin
            step(0, 1, 1, 1);
            chk("pos_to_neg_dead", cur(), 5'b00001);
        end
        step(0, 1, 1, 1);
        chk("neg", cur(), 5'b01100);

        for (int i = 0; i < DC + 2; i++) step(0, 1, 0, 0);
        chk("back_to_free", cur(), 5'b01010);

        step(0, 1, 1, 0);
        chk("pulse_dead1", cur(), 5'b00001);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("pulse_dead4", cur(), 5'b00001);
        step(0, 1, 0, 0);
        chk("pulse_absorbed", cur(), 5'b01010);

        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("en_off_mid_dead", cur(), 5'b00000);
        for (int i = 0; i < DC; i++) begin
            step(0, 1, 1, 0);
            chk("reenable_dead", cur(), 5'b00001);
        end
        step(0, 1, 1, 0);
        chk("reenable_pos", cur(), 5'b10010);

        step(0, 0, 1, 0);
        chk("en_off_mid_pos", cur(), 5'b00000);
        for (int i = 0; i < DC; i++) step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        chk("reenable_neg", cur(), 5'b01100);

        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("reset_mid_dead", cur(), 5'b00000);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? ~sign : sign);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
